// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and hands {inst, pc} to decode.
// Optional FS_INST_BUF_EN holds the fetched word in a local buffer while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned AW = 32;

  logic          r_fs_valid;
  logic [AW-1:0] r_fs_pc;
  logic          r_br_pend;
  logic [AW-1:0] r_br_pend_target;

  logic          w_br_stall;
  logic          w_br_taken;
  logic [AW-1:0] w_br_target;
  logic          w_to_fs_valid;
  logic [AW-1:0] w_seq_pc;
  logic [AW-1:0] w_nextpc;
  logic          w_fs_allowin;
  logic          w_issue;
  logic [AW-1:0] w_fs_inst;

  assign w_br_stall  = br_bus[33];
  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];

  // Pre-IF: choose the next fetch address; a latched redirect wins over a live one
  assign w_to_fs_valid = !reset;
  assign w_seq_pc      = AW'(r_fs_pc + 32'd4);
  assign w_nextpc      = r_br_pend  ? r_br_pend_target :
                         w_br_taken ? w_br_target      : w_seq_pc;

  assign w_fs_allowin = !r_fs_valid || ds_allowin;
  assign w_issue      = w_to_fs_valid && w_fs_allowin && !w_br_stall;

  assign fs_to_ds_valid  = r_fs_valid;
  assign fs_to_ds_bus    = {w_fs_inst, r_fs_pc};
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid       <= 1'b0;
      r_fs_pc          <= AW'(RESET_PC - 32'd4);
      r_br_pend        <= 1'b0;
      r_br_pend_target <= '0;
    end else begin
      if (w_issue) begin
        r_fs_pc    <= w_nextpc;
        r_fs_valid <= 1'b1;
        r_br_pend  <= 1'b0;
      end else if (w_fs_allowin && w_br_stall) begin
        r_fs_valid <= 1'b0;
      end
      // Remember a redirect that could not be issued; the newest target wins
      if (w_br_taken && !w_issue) begin
        r_br_pend        <= 1'b1;
        r_br_pend_target <= w_br_target;
      end
    end
  end

`ifdef FS_INST_BUF_EN
  logic          r_buf_valid;
  logic [AW-1:0] r_inst_buf;

  // Capture the SRAM word on the first stalled cycle so the SRAM can idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_inst_buf  <= '0;
    end else if (w_issue) begin
      r_buf_valid <= 1'b0;
    end else if (r_fs_valid && !ds_allowin && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_inst_buf  <= inst_sram_rdata;
    end
  end

  assign w_fs_inst      = r_buf_valid ? r_inst_buf : inst_sram_rdata;
  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = w_nextpc;
`else
  logic w_reread;

  // Without a buffer, re-read the held PC so rdata stays valid through the stall
  assign w_reread       = !reset && r_fs_valid && !ds_allowin;
  assign w_fs_inst      = inst_sram_rdata;
  assign inst_sram_en   = w_issue || w_reread;
  assign inst_sram_addr = w_issue ? w_nextpc : r_fs_pc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table with hand-computed PCs/addresses plus reset checks.
// The SRAM model returns addr^KEY for an enabled read and garbage after an idle cycle.
module tb_fetch_stage;

  localparam logic [31:0] KEY     = 32'h1234_5678;
  localparam logic [31:0] GARBAGE = 32'hdead_beef;
  localparam int unsigned NV      = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ KEY) : GARBAGE;

  typedef struct {
    logic        rst;
    logic        ai;
    logic        stall;
    logic        taken;
    logic [31:0] tgt;
    logic        chk_v;  // skip valid check in the cycle reset is first applied
    logic        ev;
    logic [31:0] epc;
    logic        een;    // enable when not a decode-stall row
    logic [31:0] eaddr;
    logic        dstl;   // decode stall with valid in IF: en/addr depend on build
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(logic rst, logic ai, logic stall, logic taken, logic [31:0] tgt,
                              logic chk_v, logic ev, logic [31:0] epc, logic een,
                              logic [31:0] eaddr, logic dstl);
    vec_t v;
    v.rst = rst; v.ai = ai; v.stall = stall; v.taken = taken; v.tgt = tgt;
    v.chk_v = chk_v; v.ev = ev; v.epc = epc; v.een = een; v.eaddr = eaddr; v.dstl = dstl;
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, got, exp);
    end
  endtask

  initial begin
    logic        e_en;
    logic [31:0] e_addr;
    logic [31:0] e_inst;

    // sequential fetch
    vt[0]  = mk(0,1,0,0,32'h0,        1,0,32'hbfbffffc,1,32'hbfc00000,0);
    vt[1]  = mk(0,1,0,0,32'h0,        1,1,32'hbfc00000,1,32'hbfc00004,0);
    vt[2]  = mk(0,1,0,0,32'h0,        1,1,32'hbfc00004,1,32'hbfc00008,0);
    // decode stall for 3 cycles holding bfc00008
    vt[3]  = mk(0,0,0,0,32'h0,        1,1,32'hbfc00008,0,32'h0,1);
    vt[4]  = mk(0,0,0,0,32'h0,        1,1,32'hbfc00008,0,32'h0,1);
    vt[5]  = mk(0,0,0,0,32'h0,        1,1,32'hbfc00008,0,32'h0,1);
    vt[6]  = mk(0,1,0,0,32'h0,        1,1,32'hbfc00008,1,32'hbfc0000c,0);
    // branch arrives during a stall, deasserted before release
    vt[7]  = mk(0,0,0,1,32'hbfc00200, 1,1,32'hbfc0000c,0,32'h0,1);
    vt[8]  = mk(0,0,0,0,32'h0,        1,1,32'hbfc0000c,0,32'h0,1);
    vt[9]  = mk(0,1,0,0,32'h0,        1,1,32'hbfc0000c,1,32'hbfc00200,0);
    vt[10] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00200,1,32'hbfc00204,0);
    // br_stall for 2 cycles, then resolved taken
    vt[11] = mk(0,1,1,0,32'h0,        1,1,32'hbfc00204,0,32'h0,0);
    vt[12] = mk(0,1,1,0,32'h0,        1,0,32'hbfc00204,0,32'h0,0);
    vt[13] = mk(0,1,0,1,32'hbfc00300, 1,0,32'hbfc00204,1,32'hbfc00300,0);
    vt[14] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00300,1,32'hbfc00304,0);
    // pending redirect wiped by reset
    vt[15] = mk(0,0,0,1,32'hbfc00400, 1,1,32'hbfc00304,0,32'h0,1);
    vt[16] = mk(1,1,0,0,32'h0,        0,0,32'hbfc00304,0,32'h0,0);
    vt[17] = mk(0,1,0,0,32'h0,        1,0,32'hbfbffffc,1,32'hbfc00000,0);
    vt[18] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00000,1,32'hbfc00004,0);
    // taken branch while IF holds bfc00004; delay slot still delivered
    vt[19] = mk(0,1,0,1,32'hbfc00100, 1,1,32'hbfc00004,1,32'hbfc00100,0);
    vt[20] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00100,1,32'hbfc00104,0);
    // two redirects during one stall: newest target kept
    vt[21] = mk(0,0,0,1,32'hbfc00500, 1,1,32'hbfc00104,0,32'h0,1);
    vt[22] = mk(0,0,0,1,32'hbfc00600, 1,1,32'hbfc00104,0,32'h0,1);
    vt[23] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00104,1,32'hbfc00600,0);
    vt[24] = mk(0,1,0,0,32'h0,        1,1,32'hbfc00600,1,32'hbfc00604,0);

    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;

    // held reset: outputs quiet, PC parked one word below the reset vector
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst_valid", -1, 64'(fs_to_ds_valid), 64'd0);
      chk("rst_en",    -1, 64'(inst_sram_en),   64'd0);
      chk("rst_pc",    -1, 64'(fs_to_ds_bus[31:0]), 64'hbfbffffc);
    end
    chk("wen",   -1, 64'(inst_sram_wen),   64'd0);
    chk("wdata", -1, 64'(inst_sram_wdata), 64'd0);

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      reset      = vt[i].rst;
      ds_allowin = vt[i].ai;
      br_bus     = {vt[i].stall, vt[i].taken, vt[i].tgt};
      #1;
`ifdef FS_INST_BUF_EN
      e_en   = vt[i].dstl ? 1'b0 : vt[i].een;
      e_addr = vt[i].eaddr;
`else
      e_en   = vt[i].dstl ? 1'b1 : vt[i].een;
      e_addr = vt[i].dstl ? vt[i].epc : vt[i].eaddr;
`endif
      e_inst = vt[i].epc ^ KEY;
      if (vt[i].chk_v) chk("valid", i, 64'(fs_to_ds_valid), 64'(vt[i].ev));
      chk("pc", i, 64'(fs_to_ds_bus[31:0]), 64'(vt[i].epc));
      if (vt[i].ev) chk("inst", i, 64'(fs_to_ds_bus[63:32]), 64'(e_inst));
      chk("en", i, 64'(inst_sram_en), 64'(e_en));
      if (e_en) chk("addr", i, 64'(inst_sram_addr), 64'(e_addr));
    end

    // reset applied mid-stream: valid drops after the edge and the vector restarts
    @(negedge clk);
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    @(negedge clk); #1;
    chk("mid_rst_valid", -1, 64'(fs_to_ds_valid), 64'd0);
    chk("mid_rst_en",    -1, 64'(inst_sram_en),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_addr", -1, 64'(inst_sram_addr), 64'hbfc00000);
    chk("post_rst_en",   -1, 64'(inst_sram_en),   64'd1);
    @(negedge clk); #1;
    chk("post_rst_bus", -1, fs_to_ds_bus, {32'hbfc00000 ^ KEY, 32'hbfc00000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
